// File: rtl/riscv_alu_ahb_seq_if.sv
// Job, result and AHB-lite master signals of the ALU bus sequencer.
// master: sequencer side; slave: job source / result sink / AHB slave side.
interface riscv_alu_ahb_seq_if #(
  parameter int W_BURST = 3
);
  logic               i_job_valid;
  logic               o_job_ready;
  logic [3:0]         i_job_op;
  logic [31:0]        i_job_a;
  logic [31:0]        i_job_b;
  logic               o_res_valid;
  logic               i_res_ready;
  logic [31:0]        o_res_data;
  logic               o_res_err;
  logic [15:0]        o_job_cnt;
  logic [31:0]        o_HADDR;
  logic [31:0]        o_HWDATA;
  logic               o_HWRITE;
  logic [2:0]         o_HSIZE;
  logic [W_BURST-1:0] o_HBURST;
  logic [1:0]         o_HTRANS;
  logic [31:0]        i_HRDATA;
  logic [1:0]         i_HRESP;
  logic               i_HREADY;

  modport master (
    input  i_job_valid, i_job_op, i_job_a, i_job_b,
    input  i_res_ready,
    input  i_HRDATA, i_HRESP, i_HREADY,
    output o_job_ready, o_res_valid, o_res_data,
    output o_res_err, o_job_cnt,
    output o_HADDR, o_HWDATA, o_HWRITE,
    output o_HSIZE, o_HBURST, o_HTRANS
  );

  modport slave (
    output i_job_valid, i_job_op, i_job_a, i_job_b,
    output i_res_ready,
    output i_HRDATA, i_HRESP, i_HREADY,
    input  o_job_ready, o_res_valid, o_res_data,
    input  o_res_err, o_job_cnt,
    input  o_HADDR, o_HWDATA, o_HWRITE,
    input  o_HSIZE, o_HBURST, o_HTRANS
  );
endinterface

// File: rtl/riscv_alu_ahb_seq.sv
// AHB-lite master: one ALU job -> W A, W B, W OP, R P -> result.
// Ports: HCLK, HRESET (async, high), bus (job/result/AHB master).
module riscv_alu_ahb_seq #(
  parameter logic [31:0] BASE_ADDR = 32'hE0000000,
  parameter int          W_BURST   = 3
) (
  input logic                 HCLK,
  input logic                 HRESET,
  riscv_alu_ahb_seq_if.master bus
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] RESP_ERR  = 2'b01;
  localparam logic [W_BURST-1:0] BURST_SINGLE = '0;

  localparam logic [31:0] ADDR_OP = BASE_ADDR + 32'h0;
  localparam logic [31:0] ADDR_A  = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_B  = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_P  = BASE_ADDR + 32'hC;

  typedef enum logic [3:0] {
    IDLE, A_ADDR, A_DATA, B_ADDR, B_DATA,
    OP_ADDR, OP_DATA, P_ADDR, P_DATA, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        err_q;
  logic [31:0] res_data_q;
  logic        res_err_q;
  logic [15:0] cnt_q;

  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        done, is_err, fail, dphase;

  assign done   = bus.i_HREADY;
  assign is_err = (bus.i_HRESP == RESP_ERR);
  // An error seen in a wait state counts at completion too.
  assign fail   = err_q | is_err;
  assign dphase = (state_q == A_DATA) || (state_q == B_DATA) ||
                  (state_q == OP_DATA) || (state_q == P_DATA);

  always_comb begin
    state_d = state_q;
    haddr   = '0;
    hwdata  = '0;
    htrans  = TR_IDLE;
    hwrite  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_job_valid) state_d = A_ADDR;
      end
      A_ADDR: begin
        htrans = TR_NONSEQ;
        haddr  = ADDR_A;
        hwrite = 1'b1;
        if (done) state_d = A_DATA;
      end
      A_DATA: begin
        haddr  = ADDR_A;
        hwdata = a_q;
        if (done) state_d = fail ? RESP : B_ADDR;
      end
      B_ADDR: begin
        htrans = TR_NONSEQ;
        haddr  = ADDR_B;
        hwrite = 1'b1;
        if (done) state_d = B_DATA;
      end
      B_DATA: begin
        haddr  = ADDR_B;
        hwdata = b_q;
        if (done) state_d = fail ? RESP : OP_ADDR;
      end
      OP_ADDR: begin
        htrans = TR_NONSEQ;
        haddr  = ADDR_OP;
        hwrite = 1'b1;
        if (done) state_d = OP_DATA;
      end
      OP_DATA: begin
        haddr  = ADDR_OP;
        hwdata = {28'b0, op_q};
        if (done) state_d = fail ? RESP : P_ADDR;
      end
      P_ADDR: begin
        htrans = TR_NONSEQ;
        haddr  = ADDR_P;
        if (done) state_d = P_DATA;
      end
      P_DATA: begin
        haddr = ADDR_P;
        if (done) state_d = RESP;
      end
      RESP: begin
        if (bus.i_res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.i_job_valid) begin
        op_q  <= bus.i_job_op;
        a_q   <= bus.i_job_a;
        b_q   <= bus.i_job_b;
        err_q <= 1'b0;
      end
      if (dphase && !done && is_err) err_q <= 1'b1;
      if (dphase && done && (fail || state_q == P_DATA)) begin
        res_err_q  <= fail;
        res_data_q <= fail ? '0 : bus.i_HRDATA;
      end
      if (state_q == RESP && bus.i_res_ready)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.o_job_ready = (state_q == IDLE);
  assign bus.o_res_valid = (state_q == RESP);
  assign bus.o_res_data  = res_data_q;
  assign bus.o_res_err   = res_err_q;
  assign bus.o_job_cnt   = cnt_q;
  assign bus.o_HADDR     = haddr;
  assign bus.o_HWDATA    = hwdata;
  assign bus.o_HWRITE    = hwrite;
  assign bus.o_HTRANS    = htrans;
  assign bus.o_HSIZE     = 3'b010;
  assign bus.o_HBURST    = BURST_SINGLE;
endmodule
